// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM states and
// the legal operand width range.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

  function automatic bit width_ok(int unsigned w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Request/result bundle of serial_addsub; slave is the arithmetic unit,
// master is the requester.
interface serial_addsub_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start_i;
  logic             sub_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] sum_o;
  logic             carry_o;
  logic             overflow_o;
  logic             ser_sum_o;
  logic             ser_valid_o;

  modport slave (
    input  start_i, sub_i, a_i, b_i,
    output busy_o, done_o, sum_o, carry_o, overflow_o, ser_sum_o, ser_valid_o
  );

  modport master (
    output start_i, sub_i, a_i, b_i,
    input  busy_o, done_o, sum_o, carry_o, overflow_o, ser_sum_o, ser_valid_o
  );
endinterface

// File: rtl/serial_bit_cell.sv
// One full-adder cell with a registered carry; the carry is preloaded with
// the subtract flag so that a - b becomes a + ~b + 1.
module serial_bit_cell (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic load_val_i,
  input  logic en_i,
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic cout_o,
  output logic cin_o
);
  logic carry_q;

  assign cin_o  = carry_q;
  assign s_o    = a_i ^ b_i ^ carry_q;
  assign cout_o = (a_i & b_i) | (a_i & carry_q) | (b_i & carry_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      carry_q <= 1'b0;
    end else if (load_i) begin
      carry_q <= load_val_i;
    end else if (en_i) begin
      carry_q <= cout_o;
    end
  end
endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: loads two operands, processes one bit per
// clock LSB first, then presents the parallel result with carry/overflow.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  serial_addsub_if.slave bus
);
  localparam int unsigned   CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  if (!width_ok(WIDTH)) begin : g_width_bad
    $error("serial_addsub: WIDTH must be within 2..32");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rega_q, rega_d;
  logic [WIDTH-1:0] regb_q, regb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic cell_load, cell_en, cell_s, cell_cout, cell_cin;

  serial_bit_cell u_cell (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (cell_load),
    .load_val_i (bus.sub_i),
    .en_i       (cell_en),
    .a_i        (rega_q[0]),
    .b_i        (regb_q[0]),
    .s_o        (cell_s),
    .cout_o     (cell_cout),
    .cin_o      (cell_cin)
  );

  always_comb begin
    state_d   = state_q;
    rega_d    = rega_q;
    regb_d    = regb_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    cell_load = 1'b0;
    cell_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          cell_load = 1'b1;
          rega_d    = bus.a_i;
          regb_d    = bus.sub_i ? ~bus.b_i : bus.b_i;
          cnt_d     = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        cell_en = 1'b1;
        rega_d  = rega_q >> 1;
        regb_d  = regb_q >> 1;
        acc_d   = {cell_s, acc_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
        // Results are committed on the last bit so they appear exactly in DONE
        // and stay untouched while a later operation is shifting.
        if (cnt_q == LAST) begin
          sum_d   = {cell_s, acc_q[WIDTH-1:1]};
          carry_d = cell_cout;
          ovf_d   = cell_cin ^ cell_cout;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      rega_q  <= '0;
      regb_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rega_q  <= rega_d;
      regb_q  <= regb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy_o      = (state_q == ST_SHIFT);
  assign bus.ser_valid_o = (state_q == ST_SHIFT);
  assign bus.ser_sum_o   = (state_q == ST_SHIFT) & cell_s;
  assign bus.done_o      = (state_q == ST_DONE);
  assign bus.sum_o       = sum_q;
  assign bus.carry_o     = carry_q;
  assign bus.overflow_o  = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub at widths 8, 2, 16 and 32 against an arithmetic
// reference model, with literal expectations for the width-8 vectors.
module tb_serial_addsub;
  localparam int NI = 4;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        v;
  } res_t;

  function automatic int unsigned wof(int i);
    case (i)
      0:       return 8;
      1:       return 2;
      2:       return 16;
      default: return 32;
    endcase
  endfunction

  // Reference: plain integer arithmetic; overflow means the signed result
  // does not fit in w bits.
  function automatic res_t ref_op(int unsigned w, logic sub, logic [31:0] a, logic [31:0] b);
    res_t r;
    longint unsigned m, ua, ub, tot;
    longint half, sa, sb, sr;
    m    = (64'd1 << w) - 64'd1;
    ua   = {32'd0, a} & m;
    ub   = {32'd0, b} & m;
    tot  = sub ? (ua + (~ub & m) + 64'd1) : (ua + ub);
    half = longint'(64'd1 << (w - 1));
    sa   = (ua >= longint'(half)) ? longint'(ua) - 2 * half : longint'(ua);
    sb   = (ub >= longint'(half)) ? longint'(ub) - 2 * half : longint'(ub);
    sr   = sub ? (sa - sb) : (sa + sb);
    r.s  = 32'(tot & m);
    r.c  = tot[w];
    r.v  = (sr < -half) || (sr >= half);
    return r;
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        drv_start[NI];
  logic        drv_sub[NI];
  logic [31:0] drv_a[NI];
  logic [31:0] drv_b[NI];
  logic        obs_busy[NI], obs_done[NI], obs_c[NI], obs_v[NI], obs_ss[NI], obs_sv[NI];
  logic [31:0] obs_sum[NI];

  serial_addsub_if #(.WIDTH(8))  if8  ();
  serial_addsub_if #(.WIDTH(2))  if2  ();
  serial_addsub_if #(.WIDTH(16)) if16 ();
  serial_addsub_if #(.WIDTH(32)) if32 ();

  serial_addsub #(.WIDTH(8))  u_dut8  (.clk_i(clk), .rst_i(rst), .bus(if8));
  serial_addsub #(.WIDTH(2))  u_dut2  (.clk_i(clk), .rst_i(rst), .bus(if2));
  serial_addsub #(.WIDTH(16)) u_dut16 (.clk_i(clk), .rst_i(rst), .bus(if16));
  serial_addsub #(.WIDTH(32)) u_dut32 (.clk_i(clk), .rst_i(rst), .bus(if32));

  assign if8.start_i  = drv_start[0];
  assign if8.sub_i    = drv_sub[0];
  assign if8.a_i      = drv_a[0][7:0];
  assign if8.b_i      = drv_b[0][7:0];
  assign if2.start_i  = drv_start[1];
  assign if2.sub_i    = drv_sub[1];
  assign if2.a_i      = drv_a[1][1:0];
  assign if2.b_i      = drv_b[1][1:0];
  assign if16.start_i = drv_start[2];
  assign if16.sub_i   = drv_sub[2];
  assign if16.a_i     = drv_a[2][15:0];
  assign if16.b_i     = drv_b[2][15:0];
  assign if32.start_i = drv_start[3];
  assign if32.sub_i   = drv_sub[3];
  assign if32.a_i     = drv_a[3];
  assign if32.b_i     = drv_b[3];

  assign obs_busy[0] = if8.busy_o;   assign obs_done[0] = if8.done_o;
  assign obs_c[0]    = if8.carry_o;  assign obs_v[0]    = if8.overflow_o;
  assign obs_ss[0]   = if8.ser_sum_o; assign obs_sv[0]  = if8.ser_valid_o;
  assign obs_sum[0]  = 32'(if8.sum_o);
  assign obs_busy[1] = if2.busy_o;   assign obs_done[1] = if2.done_o;
  assign obs_c[1]    = if2.carry_o;  assign obs_v[1]    = if2.overflow_o;
  assign obs_ss[1]   = if2.ser_sum_o; assign obs_sv[1]  = if2.ser_valid_o;
  assign obs_sum[1]  = 32'(if2.sum_o);
  assign obs_busy[2] = if16.busy_o;  assign obs_done[2] = if16.done_o;
  assign obs_c[2]    = if16.carry_o; assign obs_v[2]    = if16.overflow_o;
  assign obs_ss[2]   = if16.ser_sum_o; assign obs_sv[2] = if16.ser_valid_o;
  assign obs_sum[2]  = 32'(if16.sum_o);
  assign obs_busy[3] = if32.busy_o;  assign obs_done[3] = if32.done_o;
  assign obs_c[3]    = if32.carry_o; assign obs_v[3]    = if32.overflow_o;
  assign obs_ss[3]   = if32.ser_sum_o; assign obs_sv[3] = if32.ser_valid_o;
  assign obs_sum[3]  = if32.sum_o;

  // Model: per instance, whether an operation is in flight, how many edges
  // since acceptance, the pending result and the result currently presented.
  logic m_init = 1'b0;
  logic m_act[NI];
  int   m_k[NI];
  res_t m_p[NI];
  res_t m_e[NI];

  always @(posedge clk) begin
    if (rst) m_init <= 1'b1;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        m_act[i] <= 1'b0;
        m_k[i]   <= 0;
        m_e[i]   <= '0;
      end else if (!m_act[i]) begin
        if (drv_start[i]) begin
          m_act[i] <= 1'b1;
          m_k[i]   <= 0;
          m_p[i]   <= ref_op(wof(i), drv_sub[i], drv_a[i], drv_b[i]);
        end
      end else begin
        m_k[i] <= m_k[i] + 1;
        if (m_k[i] == int'(wof(i)) - 1) m_e[i] <= m_p[i];
        if (m_k[i] == int'(wof(i))) m_act[i] <= 1'b0;
      end
    end
  end

  // Literal expectations for the current width-8 operation.
  logic       lit_on = 1'b0;
  logic [7:0] lit_sum;
  logic       lit_c, lit_v;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string nm, int i, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s w=%0d got=%h want=%h t=%0t", nm, wof(i), got, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (m_init) begin
      for (int i = 0; i < NI; i++) begin
        logic eb, ed, es;
        eb = m_act[i] && (m_k[i] < int'(wof(i)));
        ed = m_act[i] && (m_k[i] == int'(wof(i)));
        es = eb ? m_p[i].s[m_k[i]] : 1'b0;
        chk("busy", i, 32'(obs_busy[i]), 32'(eb));
        chk("ser_valid", i, 32'(obs_sv[i]), 32'(eb));
        chk("ser_sum", i, 32'(obs_ss[i]), 32'(es));
        chk("done", i, 32'(obs_done[i]), 32'(ed));
        chk("sum", i, obs_sum[i], m_e[i].s);
        chk("carry", i, 32'(obs_c[i]), 32'(m_e[i].c));
        chk("overflow", i, 32'(obs_v[i]), 32'(m_e[i].v));
        if (i == 0 && lit_on && eb)
          chk("lit_ser", i, 32'(obs_ss[0]), 32'(lit_sum[m_k[0]]));
        if (i == 0 && lit_on && ed) begin
          chk("lit_sum", i, obs_sum[0], 32'(lit_sum));
          chk("lit_carry", i, 32'(obs_c[0]), 32'(lit_c));
          chk("lit_overflow", i, 32'(obs_v[0]), 32'(lit_v));
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle start; operands are scrambled afterwards and must not matter.
  task automatic issue(int i, logic sub, logic [31:0] a, logic [31:0] b);
    drv_start[i] = 1'b1;
    drv_sub[i]   = sub;
    drv_a[i]     = a;
    drv_b[i]     = b;
    tick(1);
    drv_start[i] = 1'b0;
    drv_sub[i]   = 1'($urandom);
    drv_a[i]     = $urandom;
    drv_b[i]     = $urandom;
  endtask

  task automatic run_lit(logic sub, logic [7:0] a, logic [7:0] b,
                         logic [7:0] s, logic c, logic v);
    lit_sum = s;
    lit_c   = c;
    lit_v   = v;
    lit_on  = 1'b1;
    issue(0, sub, 32'(a), 32'(b));
    tick(10);
    lit_on  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      drv_start[i] = 1'b0;
      drv_sub[i]   = 1'b0;
      drv_a[i]     = '0;
      drv_b[i]     = '0;
    end
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);

    run_lit(1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1);
    run_lit(1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    run_lit(1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0);
    run_lit(1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
    run_lit(1'b1, 8'h33, 8'h33, 8'h00, 1'b1, 1'b0);

    // start held high with changing operands through SHIFT and DONE
    lit_sum = 8'h46; lit_c = 1'b0; lit_v = 1'b0; lit_on = 1'b1;
    drv_start[0] = 1'b1; drv_sub[0] = 1'b0;
    drv_a[0] = 32'h12; drv_b[0] = 32'h34;
    tick(1);
    drv_a[0] = 32'h70; drv_b[0] = 32'h70;
    tick(9);
    lit_on = 1'b0;
    tick(1);
    drv_start[0] = 1'b0;
    tick(10);

    // reset during the 4th SHIFT cycle, then a fresh operation
    issue(0, 1'b1, 32'h5A, 32'h3C);
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(3);
    run_lit(1'b1, 8'h40, 8'h41, 8'hFF, 1'b0, 1'b0);

    // sweep: boundary operands then random, issued back to back
    for (int i = 0; i < NI; i++) begin
      int w;
      w = int'(wof(i));
      issue(i, 1'b0, 32'hFFFF_FFFF, 32'h1); tick(w + 1);
      issue(i, 1'b1, 32'h1 << (w - 1), 32'h1); tick(w + 1);
      issue(i, 1'b0, 32'h1 << (w - 1), 32'h1 << (w - 1)); tick(w + 1);
      for (int n = 0; n < 12; n++) begin
        issue(i, 1'($urandom), $urandom, $urandom);
        tick(w + 1);
      end
      tick(3);
    end

    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
